// File: rtl/dot_prod_sched_if.sv
// Host-side handshake bundle for dot_prod_sched: element-pair input stream and result output.
interface dot_prod_sched_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 27
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_b;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [63:0]              out_result;
    logic [ADDR_W:0]          out_len;
    logic [1:0]               out_err;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_result, out_len, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_result, out_len, out_err
    );
endinterface

// File: rtl/dot_prod_sched.sv
// Loads operand pairs into the core's arrays, starts the core, waits for done or timeout,
// and hands the result back to the host.
//
// state | meaning
// LOAD  | host owns arrays, accepting element pairs
// DRAIN | one cycle so the final registered write lands
// START | core owns arrays, r_enable pulse
// RUN   | waiting for w_enable, tcnt counting toward TIMEOUT
// DONE  | result presented until out_ready
module dot_prod_sched #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 27,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    dot_prod_sched_if.slave   host,
    output logic              busy,
    output logic              controlArr,
    output logic              controlArrWEnable_a,
    output logic              controlArrWEnable_b,
    output logic [ADDR_W-1:0] controlArrAddr_a,
    output logic [ADDR_W-1:0] controlArrAddr_b,
    output logic [DATA_W-1:0] controlArrWData_a,
    output logic [DATA_W-1:0] controlArrWData_b,
    output logic              r_enable,
    input  logic              w_enable,
    input  logic [63:0]       result,
    output logic [63:0]       init_i,
    output logic [63:0]       init_acc
);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {LOAD, DRAIN, START, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q;
    logic [TCNT_W-1:0]   tcnt_q;
    logic [1:0]          err_q;
    logic [63:0]         res_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wa_q, wb_q;

    logic accept, at_max, expire;

    assign accept = host.in_valid && (state_q == LOAD);
    // The last addressable slot forces the load to end even without in_last.
    assign at_max = (cnt_q == {1'b0, {ADDR_W{1'b1}}});
    assign expire = (tcnt_q == TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        host.in_ready  = 1'b0;
        host.out_valid = 1'b0;
        controlArr  = 1'b1;
        r_enable    = 1'b0;
        case (state_q)
            LOAD: begin
                host.in_ready = 1'b1;
                if (accept && (host.in_last || at_max)) state_d = DRAIN;
            end
            DRAIN: state_d = START;
            START: begin
                controlArr = 1'b0;
                r_enable   = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                controlArr = 1'b0;
                if (w_enable || expire) state_d = DONE;
            end
            DONE: begin
                host.out_valid = 1'b1;
                if (host.out_ready) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tcnt_q <= '0;
            err_q  <= '0;
            res_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            wa_q   <= '0;
            wb_q   <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                addr_q <= cnt_q[ADDR_W-1:0];
                wa_q   <= host.in_a;
                wb_q   <= host.in_b;
                cnt_q  <= cnt_q + 1'b1;
                if (!host.in_last && at_max) err_q[0] <= 1'b1;
            end
            if (state_q == RUN) begin
                tcnt_q <= tcnt_q + 1'b1;
                // A done strobe on the expiry cycle still counts as success.
                if (w_enable) begin
                    res_q <= result;
                end else if (expire) begin
                    res_q    <= '0;
                    err_q[1] <= 1'b1;
                end
            end
            if (state_q == DONE && host.out_ready) begin
                cnt_q  <= '0;
                tcnt_q <= '0;
                err_q  <= '0;
            end
        end
    end

    assign busy                = (state_q != LOAD) || (cnt_q != '0);
    assign controlArrWEnable_a = we_q;
    assign controlArrWEnable_b = we_q;
    assign controlArrAddr_a    = addr_q;
    assign controlArrAddr_b    = addr_q;
    assign controlArrWData_a   = wa_q;
    assign controlArrWData_b   = wb_q;
    assign init_i              = '0;
    assign init_acc            = '0;
    assign host.out_result     = res_q;
    assign host.out_len        = cnt_q;
    assign host.out_err        = err_q;
endmodule

// File: tb/tb_dot_prod_sched.sv
// Directed bench for dot_prod_sched: bench acts as host and as the compute core.
module tb_dot_prod_sched;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 27;
    localparam int TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst;
    logic busy, controlArr, we_a, we_b, r_enable, w_enable;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wd_a, wd_b;
    logic [63:0] core_result, init_i, init_acc;

    dot_prod_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dot_prod_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .host(bus), .busy(busy), .controlArr(controlArr),
        .controlArrWEnable_a(we_a), .controlArrWEnable_b(we_b),
        .controlArrAddr_a(addr_a), .controlArrAddr_b(addr_b),
        .controlArrWData_a(wd_a), .controlArrWData_b(wd_b),
        .r_enable(r_enable), .w_enable(w_enable), .result(core_result),
        .init_i(init_i), .init_acc(init_acc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = -100;
    logic ren_prev = 1'b0;
    logic expect_done = 1'b0;
    logic [63:0] exp_result = '0;
    logic [ADDR_W:0] exp_len = '0;
    logic [1:0] exp_err = '0;
    logic signed [DATA_W-1:0] sa [1024];
    logic signed [DATA_W-1:0] sb [1024];
    logic signed [DATA_W-1:0] mem_a [1024];
    logic signed [DATA_W-1:0] mem_b [1024];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] dot_of(input int n, input bit from_mem);
        longint s = 0;
        for (int i = 0; i < n; i++)
            s += from_mem ? longint'(mem_a[i]) * longint'(mem_b[i])
                          : longint'(sa[i]) * longint'(sb[i]);
        return 64'(s);
    endfunction

    always @(posedge clk) cyc++;

    // Per-cycle compare against the bench model and protocol rules.
    always @(negedge clk) begin
        if (!rst) begin
            if (we_a) begin
                chk("we_a_while_core_owns", controlArr, 1);
                mem_a[addr_a] = wd_a;
            end
            if (we_b) begin
                chk("we_b_while_core_owns", controlArr, 1);
                mem_b[addr_b] = wd_b;
            end
            if (r_enable) begin
                chk("r_enable_latency", 64'(cyc - last_acc_cyc), 2);
                chk("r_enable_width", ren_prev, 0);
                chk("start_controlArr", controlArr, 0);
            end
            if (bus.out_valid) begin
                chk("out_result", bus.out_result, exp_result);
                chk("out_len", bus.out_len, exp_len);
                chk("out_err", bus.out_err, exp_err);
                chk("done_controlArr", controlArr, 1);
                chk("done_in_ready", bus.in_ready, 0);
            end
            chk("spurious_out_valid", bus.out_valid & ~expect_done, 0);
            chk("init_zero", init_i | init_acc, 0);
            if (bus.in_valid && bus.in_ready) last_acc_cyc = cyc;
            ren_prev = r_enable;
        end else begin
            ren_prev = 1'b0;
        end
    end

    task automatic load_vec(input int n, input bit use_last);
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        for (int i = 0; i < n; i++) begin
            bus.in_a     = sa[i];
            bus.in_b     = sb[i];
            bus.in_last  = use_last && (i == n - 1);
            bus.in_valid = 1'b1;
            if (i == 0 || i == n - 1) chk("in_ready_load", bus.in_ready, 1);
            tick();
            if (i == 0) chk("busy_after_first", busy, 1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_r_enable();
        int k = 0;
        while (!r_enable && k < 8) begin
            tick();
            k++;
        end
        chk("r_enable_seen", r_enable, 1);
    endtask

    // core_delay < 0 means the core never answers.
    task automatic run_vec(input int n, input bit use_last, input int core_delay, input int hold,
                           input logic [63:0] lit_res, input logic [ADDR_W:0] lit_len,
                           input logic [1:0] lit_err);
        int k = 0;
        int bad = 0;
        exp_len    = (ADDR_W+1)'(n);
        exp_err    = {core_delay < 0, !use_last && n == 1024};
        exp_result = (core_delay < 0) ? 64'd0 : dot_of(n, 1'b0);
        expect_done = 1'b1;
        load_vec(n, use_last);
        wait_r_enable();
        tick();
        k = 1;
        if (core_delay >= 0) begin
            repeat (core_delay) begin
                tick();
                k++;
            end
            w_enable    = 1'b1;
            core_result = dot_of(n, 1'b1);
            tick();
            k++;
            w_enable    = 1'b0;
            core_result = 64'hDEAD_BEEF_0000_0001;
        end else begin
            while (!bus.out_valid && k < TIMEOUT + 10) begin
                tick();
                k++;
            end
        end
        chk("done_latency", 64'(k), (core_delay < 0) ? 64'(TIMEOUT + 1) : 64'(core_delay + 2));
        chk("out_valid_done", bus.out_valid, 1);
        chk("lit_result", bus.out_result, lit_res);
        chk("lit_len", bus.out_len, lit_len);
        chk("lit_err", bus.out_err, lit_err);
        for (int i = 0; i < n; i++)
            if (mem_a[i] !== sa[i] || mem_b[i] !== sb[i]) bad++;
        chk("array_contents", 64'(bad), 0);
        repeat (hold) begin
            tick();
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        expect_done = 1'b0;
        chk("after_in_ready", bus.in_ready, 1);
        chk("after_out_valid", bus.out_valid, 0);
        chk("after_busy", busy, 0);
        chk("after_err", bus.out_err, 0);
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog expired cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        w_enable = 1'b0;
        core_result = '0;
        repeat (3) tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_len", bus.out_len, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_r_enable", r_enable, 0);
        chk("rst_we", {we_a, we_b}, 0);
        chk("rst_addr", {addr_a, addr_b}, 0);
        chk("rst_wdata", {wd_a, wd_b}, 0);
        chk("rst_controlArr", controlArr, 1);
        chk("rst_init", init_i | init_acc, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        tick();

        // (1,2),(3,4),(5,6) -> 44, result held for 10 cycles before out_ready
        sa[0] = 1; sb[0] = 2; sa[1] = 3; sb[1] = 4; sa[2] = 5; sb[2] = 6;
        run_vec(3, 1'b1, 3, 10, 64'd44, 11'd3, 2'b00);

        // signed operands: -63 - 200 + 0 + 1000 = 737
        sa[0] = -7; sb[0] = 9; sa[1] = 100; sb[1] = -2;
        sa[2] = 0;  sb[2] = 5; sa[3] = -1;  sb[3] = -1000;
        run_vec(4, 1'b1, 0, 0, 64'd737, 11'd4, 2'b00);

        // full array without in_last: 1023*2 + 5*2 = 2056, overflow flagged
        for (int i = 0; i < 1024; i++) begin
            sa[i] = 1;
            sb[i] = 2;
        end
        sa[1023] = 5;
        run_vec(1024, 1'b0, 1, 2, 64'd2056, 11'd1024, 2'b01);

        // core silent -> timeout
        sa[0] = 3; sb[0] = 4;
        run_vec(1, 1'b1, -1, 1, 64'd0, 11'd1, 2'b10);

        // done strobe exactly on the expiry cycle: 20 + 60 = 80, no timeout flag
        sa[0] = 2; sb[0] = 10; sa[1] = 3; sb[1] = 20;
        run_vec(2, 1'b1, TIMEOUT - 1, 0, 64'd80, 11'd2, 2'b00);

        // reset in the middle of RUN, late done strobe ignored
        sa[0] = 7; sb[0] = 7; sa[1] = 8; sb[1] = 8; sa[2] = 9; sb[2] = 9;
        load_vec(3, 1'b1);
        wait_r_enable();
        repeat (5) tick();
        chk("mid_run_controlArr", controlArr, 0);
        rst = 1'b1;
        #1;
        chk("abort_controlArr", controlArr, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        tick();
        rst = 1'b0;
        w_enable = 1'b1;
        core_result = 64'd999;
        tick();
        w_enable = 1'b0;
        repeat (5) begin
            tick();
            chk("abort_no_out_valid", bus.out_valid, 0);
            chk("abort_in_ready", bus.in_ready, 1);
        end
        chk("abort_out_result", bus.out_result, 0);

        // fresh 2-element load after the abort: -3 - 8 = -11
        sa[0] = -1; sb[0] = 3; sa[1] = -2; sb[1] = 4;
        run_vec(2, 1'b1, 2, 0, -64'sd11, 11'd2, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
